stack_unit: RTL and testbench
=============================

# stack_unit

Hardware LIFO that sits on the controller's stack port of the multi-cycle stack-machine datapath. It executes the push/pop/tos strobes issued each cycle by the controller and holds the operand stack. It exposes top-of-stack (TOS) and next-on-stack (NOS) to the ALU and the zero flag for JZ. It also reports occupancy, full/empty status and, when enabled, sticky overflow/underflow errors.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 16, number of stack entries (≥2, need not be a power of two)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- push  in  1  write din onto stack this cycle
- pop  in  1  remove top entry this cycle
- tos  in  1  peek request (no state change), validates TOS for the JZ test
- din  in  WIDTH  data to push (from memory/ALU result register)
- clr_err  in  1  clears sticky error flags
- dout  out  WIDTH  current TOS (combinational from state), 0 when empty
- nos  out  WIDTH  entry below TOS, 0 when count<2
- zero  out  1  dout==0 and not empty
- count  out  $clog2(DEPTH+1)  occupancy
- full  out  1  count==DEPTH
- empty  out  1  count==0
- ovf  out  1  sticky overflow (push while full)
- unf  out  1  sticky underflow (pop or tos while empty)

## Operation
- Storage: DEPTH×WIDTH register array plus stack pointer sp == count; TOS = mem[sp-1], NOS = mem[sp-2].
- Per-cycle command decode, evaluated on {push,pop}:
  - 00: hold.
  - 10, not full: mem[sp]←din, sp+1.
  - 10, full: ignored, ovf←1.
  - 01, not empty: sp-1. The popped value stays visible on dout during the pop cycle.
  - 01, empty: ignored, unf←1.
  - 11, not empty: replace, mem[sp-1]←din, sp unchanged.
  - 11, empty: behaves as plain push, no error.
- tos has no effect on storage. tos while empty sets unf. tos combined with push/pop is legal and does not alter the above.
- Errors are sticky until clr_err or rst. clr_err in the same cycle as a new error leaves the flag set (set wins).
- Array contents are not reset. Only sp and the flags are reset.

## Timing
- Reset values: sp=0, so count=0, empty=1, full=0, dout=0, nos=0, zero=0; ovf=0, unf=0.
- rst asserted mid-operation clears sp and the flags immediately (async). Any command in that cycle is discarded.
- dout, nos, zero, full, empty and count are combinational from registered state only: no din→dout path, zero-cycle read latency.
- Push/pop/replace take effect at the rising edge. The new TOS is visible in the following cycle (1-cycle write latency).
- Sustained one command per cycle. No stall or handshake: the controller is responsible for ordering. Illegal commands are dropped, never corrupting state.
- sp never wraps: saturates at 0 and DEPTH.

## Configuration
- STACK_ERR_EN defined: ovf/unf sticky flags and clr_err are implemented as above.
- STACK_ERR_EN undefined: ovf and unf are tied 0 and clr_err is ignored. Illegal push/pop are still dropped silently, with identical stack behaviour.

## Structure
- Shared package stack_pkg:
  - default WIDTH/DEPTH constants
  - the controller opcode constants (ADD 000, SUB 001, AND 010, NOT 011, PUSH 100, POP 101, JMP 110, JZ 111), so the controller and bench share one definition
  - the stack command encoding {push,pop}: HOLD, PUSH, POP, REPL
- One sub-module, stack_regfile: DEPTH×WIDTH array with one synchronous write port and two combinational read ports (TOS, NOS). stack_unit keeps sp, command decode and flags.

## Test plan
- Reset then idle: after rst, empty=1, count=0, dout=0, zero=0, ovf=unf=0. Hold 5 cycles → unchanged.
- Push 3, 5, 0 on consecutive cycles → count=3, dout=0, zero=1, nos=5. Pop → dout=5, nos=3, zero=0, count=2.
- Replace: stack [3,5], push+pop with din=8 → count=2, dout=8, nos=3. Push+pop on empty with din=7 → count=1, dout=7, unf=0.
- Fill DEPTH entries 1..16, then push 99 → full=1, count=16, dout=16, ovf=1. clr_err → ovf=0, contents intact.
- Pop on empty → count stays 0, unf=1. tos on empty → unf=1. clr_err and pop-on-empty in the same cycle → unf stays 1.
- Assert rst asynchronously mid-burst with count=4 → count=0 and empty=1 before the next edge. Compile without STACK_ERR_EN and repeat the overflow test → ovf=0 and stack unchanged.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: shared constants for the stack-machine datapath.
// Holds the default stack geometry, the controller opcodes and the
// {push,pop} stack command encoding used by stack_unit and its controller.
package stack_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_POP  = 2'b01,
        CMD_PUSH = 2'b10,
        CMD_REPL = 2'b11
    } stack_cmd_e;
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: DEPTH x WIDTH storage, one synchronous write port, two
// combinational read ports (TOS and NOS). Contents are not reset.
// Ports: clk, i_we/i_waddr/i_wdata write port,
//        i_raddr_a/o_rdata_a and i_raddr_b/o_rdata_b read ports.
module stack_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_a,
    output logic [WIDTH-1:0] o_rdata_b
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Range guards matter only when DEPTH is not a power of two.
    logic w_wok, w_aok, w_bok;
    assign w_wok = {1'b0, i_waddr}   < (AW+1)'(DEPTH);
    assign w_aok = {1'b0, i_raddr_a} < (AW+1)'(DEPTH);
    assign w_bok = {1'b0, i_raddr_b} < (AW+1)'(DEPTH);

    always_ff @(posedge clk)
        if (i_we && w_wok) r_mem[i_waddr] <= i_wdata;

    assign o_rdata_a = w_aok ? r_mem[i_raddr_a] : '0;
    assign o_rdata_b = w_bok ? r_mem[i_raddr_b] : '0;
endmodule

// File: rtl/stack_unit.sv
// stack_unit: hardware LIFO on the controller stack port.
// Ports: clk, rst (async, active-high); i_push/i_pop/i_tos strobes,
//        i_din push data, i_clr_err clears sticky errors;
//        o_dout TOS, o_nos NOS, o_zero, o_count, o_full, o_empty, o_ovf, o_unf.
// Config: define STACK_ERR_EN to implement sticky ovf/unf and clr_err;
//         otherwise both flags are tied 0.
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_tos,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_dout,
    output logic [WIDTH-1:0] o_nos,
    output logic             o_zero,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_ovf,
    output logic             o_unf
);
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]    r_sp, w_sp_nxt;
    logic [AW-1:0]    w_tos_addr, w_nos_addr, w_waddr;
    logic [WIDTH-1:0] w_rd_tos, w_rd_nos;
    logic             w_we, w_ovf_set, w_unf_set, w_empty, w_full;
    stack_cmd_e       w_cmd;

    assign w_cmd      = stack_cmd_e'({i_push, i_pop});
    assign w_empty    = r_sp == '0;
    assign w_full     = r_sp == CW'(DEPTH);
    assign w_tos_addr = AW'(r_sp - 1'b1);
    assign w_nos_addr = AW'(r_sp - 2'd2);
    // Replace overwrites the current TOS; push (incl. replace on empty) writes at sp.
    assign w_waddr    = (i_pop && !w_empty) ? w_tos_addr : AW'(r_sp);

    always_comb begin
        w_sp_nxt  = r_sp;
        w_we      = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = i_tos && w_empty;
        case (w_cmd)
            CMD_PUSH: begin
                w_ovf_set = w_full;
                w_we      = !w_full;
                w_sp_nxt  = w_full ? r_sp : r_sp + 1'b1;
            end
            CMD_POP: begin
                w_unf_set = w_unf_set || w_empty;
                w_sp_nxt  = w_empty ? r_sp : r_sp - 1'b1;
            end
            CMD_REPL: begin
                w_we     = 1'b1;
                w_sp_nxt = w_empty ? r_sp + 1'b1 : r_sp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) r_sp <= '0;
        else     r_sp <= w_sp_nxt;

    // A command coinciding with reset must not touch the array either.
    stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_regfile (
        .clk       (clk),
        .i_we      (w_we && !rst),
        .i_waddr   (w_waddr),
        .i_wdata   (i_din),
        .i_raddr_a (w_tos_addr),
        .i_raddr_b (w_nos_addr),
        .o_rdata_a (w_rd_tos),
        .o_rdata_b (w_rd_nos)
    );

`ifdef STACK_ERR_EN
    logic r_ovf, r_unf;
    // Set wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set || (r_ovf && !i_clr_err);
            r_unf <= w_unf_set || (r_unf && !i_clr_err);
        end
    assign o_ovf = r_ovf;
    assign o_unf = r_unf;
`else
    logic w_unused;
    assign w_unused = i_clr_err ^ w_ovf_set ^ w_unf_set;
    assign o_ovf    = 1'b0;
    assign o_unf    = 1'b0;
`endif

    assign o_dout  = w_empty ? '0 : w_rd_tos;
    assign o_nos   = (r_sp < CW'(2)) ? '0 : w_rd_nos;
    assign o_zero  = !w_empty && (o_dout == '0);
    assign o_count = r_sp;
    assign o_full  = w_full;
    assign o_empty = w_empty;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed self-checking bench for stack_unit.
module tb_stack_unit;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH+1);
`ifdef STACK_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic             clk, rst, push, pop, tos, clr_err;
    logic [WIDTH-1:0] din, dout, nos;
    logic [CW-1:0]    count;
    logic             zero, full, empty, ovf, unf;
    int               n_vec, n_err;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_push(push), .i_pop(pop), .i_tos(tos),
        .i_din(din), .i_clr_err(clr_err), .o_dout(dout), .o_nos(nos),
        .o_zero(zero), .o_count(count), .o_full(full), .o_empty(empty),
        .o_ovf(ovf), .o_unf(unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one command for one cycle, then return to idle 1 time unit after the edge.
    task automatic cyc(input logic p, input logic q, input logic t, input logic [WIDTH-1:0] d, input logic c);
        push = p; pop = q; tos = t; din = d; clr_err = c;
        @(posedge clk); #1;
        push = 0; pop = 0; tos = 0; din = 0; clr_err = 0;
    endtask

    task automatic test_reset;
        rst = 1; #3; rst = 0; #1;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %0d want 1", empty); end
        n_vec++; if (count !== 0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        n_vec++; if (dout !== 0) begin n_err++; $display("FAIL rst_dout got %0d want 0", dout); end
        n_vec++; if (zero !== 1'b0) begin n_err++; $display("FAIL rst_zero got %0d want 0", zero); end
        n_vec++; if ({ovf, unf} !== 2'b00) begin n_err++; $display("FAIL rst_flags got %b want 00", {ovf, unf}); end
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'd0, 0);
        n_vec++; if ({empty, full, zero, ovf, unf} !== 5'b10000 || count !== 0 || nos !== 0)
            begin n_err++; $display("FAIL hold_idle got %b/%0d want 10000/0", {empty, full, zero, ovf, unf}, count); end
    endtask

    task automatic test_push_pop;
        cyc(1, 0, 0, 8'd3, 0);
        cyc(1, 0, 0, 8'd5, 0);
        cyc(1, 0, 0, 8'd0, 0);
        n_vec++; if (count !== 3) begin n_err++; $display("FAIL pp_count got %0d want 3", count); end
        n_vec++; if (dout !== 0 || zero !== 1'b1) begin n_err++; $display("FAIL pp_zero got %0d/%0d want 0/1", dout, zero); end
        n_vec++; if (nos !== 5) begin n_err++; $display("FAIL pp_nos got %0d want 5", nos); end
        pop = 1; #1;
        n_vec++; if (dout !== 0 || count !== 3) begin n_err++; $display("FAIL pop_cycle got %0d/%0d want 0/3", dout, count); end
        cyc(0, 1, 0, 8'd0, 0);
        n_vec++; if (dout !== 5 || nos !== 3 || zero !== 1'b0 || count !== 2)
            begin n_err++; $display("FAIL after_pop got %0d/%0d/%0d/%0d want 5/3/0/2", dout, nos, zero, count); end
    endtask

    task automatic test_replace;
        cyc(1, 1, 0, 8'd8, 0);
        n_vec++; if (count !== 2 || dout !== 8 || nos !== 3)
            begin n_err++; $display("FAIL repl got %0d/%0d/%0d want 2/8/3", count, dout, nos); end
        cyc(0, 1, 0, 8'd0, 0);
        cyc(0, 1, 0, 8'd0, 0);
        n_vec++; if (empty !== 1'b1 || unf !== 1'b0) begin n_err++; $display("FAIL repl_drain got %0d/%0d want 1/0", empty, unf); end
        cyc(1, 1, 0, 8'd7, 0);
        n_vec++; if (count !== 1 || dout !== 7 || unf !== 1'b0 || nos !== 0)
            begin n_err++; $display("FAIL repl_empty got %0d/%0d/%0d want 1/7/0", count, dout, unf); end
        cyc(0, 1, 0, 8'd0, 0);
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= DEPTH; i++) cyc(1, 0, 0, 8'(i), 0);
        n_vec++; if (full !== 1'b1 || count !== 16 || dout !== 16 || ovf !== 1'b0)
            begin n_err++; $display("FAIL fill got %0d/%0d/%0d/%0d want 1/16/16/0", full, count, dout, ovf); end
        cyc(1, 0, 0, 8'd99, 0);
        n_vec++; if (full !== 1'b1 || count !== 16 || dout !== 16 || nos !== 15)
            begin n_err++; $display("FAIL ovf_state got %0d/%0d/%0d/%0d want 1/16/16/15", full, count, dout, nos); end
        n_vec++; if (ovf !== ERR) begin n_err++; $display("FAIL ovf_flag got %0d want %0d", ovf, ERR); end
        cyc(0, 0, 0, 8'd0, 1);
        n_vec++; if (ovf !== 1'b0 || count !== 16) begin n_err++; $display("FAIL ovf_clr got %0d/%0d want 0/16", ovf, count); end
        for (int i = DEPTH; i >= 1; i--) begin
            n_vec++; if (dout !== 8'(i)) begin n_err++; $display("FAIL drain got %0d want %0d", dout, i); end
            cyc(0, 1, 0, 8'd0, 0);
        end
        n_vec++; if (empty !== 1'b1 || unf !== 1'b0) begin n_err++; $display("FAIL drain_end got %0d/%0d want 1/0", empty, unf); end
    endtask

    task automatic test_underflow;
        cyc(0, 1, 0, 8'd0, 0);
        n_vec++; if (count !== 0 || unf !== ERR) begin n_err++; $display("FAIL unf_pop got %0d/%0d want 0/%0d", count, unf, ERR); end
        cyc(0, 0, 0, 8'd0, 1);
        n_vec++; if (unf !== 1'b0) begin n_err++; $display("FAIL unf_clr got %0d want 0", unf); end
        cyc(0, 0, 1, 8'd0, 0);
        n_vec++; if (unf !== ERR || count !== 0) begin n_err++; $display("FAIL unf_tos got %0d want %0d", unf, ERR); end
        cyc(0, 0, 0, 8'd0, 1);
        cyc(0, 1, 0, 8'd0, 1);
        n_vec++; if (unf !== ERR) begin n_err++; $display("FAIL unf_setwins got %0d want %0d", unf, ERR); end
        cyc(0, 0, 0, 8'd0, 1);
    endtask

    task automatic test_async_reset;
        cyc(0, 1, 0, 8'd0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'(20 + i), 0);
        n_vec++; if (count !== 4 || dout !== 23) begin n_err++; $display("FAIL ar_pre got %0d/%0d want 4/23", count, dout); end
        push = 1; din = 8'd50; #2; rst = 1; #1;
        n_vec++; if (count !== 0 || empty !== 1'b1 || unf !== 1'b0 || dout !== 0)
            begin n_err++; $display("FAIL ar_async got %0d/%0d/%0d want 0/1/0", count, empty, unf); end
        @(posedge clk); #1; rst = 0; push = 0; din = 0;
        cyc(0, 0, 0, 8'd0, 0);
        n_vec++; if (count !== 0 || empty !== 1'b1) begin n_err++; $display("FAIL ar_discard got %0d/%0d want 0/1", count, empty); end
    endtask

    task automatic test_back_to_back;
        cyc(1, 0, 0, 8'd10, 0);
        cyc(1, 0, 0, 8'd20, 0);
        cyc(0, 1, 0, 8'd0, 0);
        cyc(1, 0, 1, 8'd30, 0);
        n_vec++; if (count !== 2 || dout !== 30 || nos !== 10 || unf !== 1'b0)
            begin n_err++; $display("FAIL b2b got %0d/%0d/%0d want 2/30/10", count, dout, nos); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1; push = 0; pop = 0; tos = 0; din = 0; clr_err = 0;
        test_reset;
        test_push_pop;
        test_replace;
        test_overflow;
        test_underflow;
        test_async_reset;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
